// File: rtl/regfile_pkg.sv
`default_nettype none
// regfile_pkg: shared types and default sizes for register_file_param. Rev 1.0
package regfile_pkg;

  typedef enum logic {IDLE, CLEAR} regfile_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
`default_nettype none
// regfile_clear_fsm: IDLE/CLEAR sequencer that walks a clear strobe over every register. Rev 1.0
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic             clear_done,
  output logic             write_ready,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_idx
);

  regfile_state_t   state, state_nx;
  logic [IDX_W-1:0] cnt, cnt_nx;
  logic             done, done_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        // requests arriving here are ignored: no restart, no extension
        if (cnt == IDX_W'(DEPTH - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + IDX_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign clear_busy  = (state == CLEAR);
  assign clr_en      = (state == CLEAR);
  assign clr_idx     = cnt;
  assign clear_done  = done;
  assign write_ready = (state == IDLE) && reset;

endmodule
`default_nettype wire

// File: rtl/register_file_param.sv
`default_nettype none
// register_file_param: DEPTH x WIDTH regfile, two combinational reads, one write, sequential bulk clear.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding. Rev 1.0
module register_file_param
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int ZERO_REG = 0,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] read_index_a,
  output logic [WIDTH-1:0] read_data_a,
  input  logic [IDX_W-1:0] read_index_b,
  output logic [WIDTH-1:0] read_data_b,
  input  logic [IDX_W-1:0] write_index,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] write_data,
  output logic             write_ready,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic             clear_done
);

  localparam int NSLOT = 1 << IDX_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] view [NSLOT];
  logic [DEPTH-1:0] wsel;
  logic             clr_en;
  logic [IDX_W-1:0] clr_idx;

  regfile_clear_fsm #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_clear_fsm (
    .clk         (clk),
    .reset       (reset),
    .clear_req   (clear_req),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .write_ready (write_ready),
    .clr_en      (clr_en),
    .clr_idx     (clr_idx)
  );

  // One-hot write select; out-of-range and hardwired-zero targets select nothing.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wsel[i] = write_enable && write_ready && (write_index == IDX_W'(i))
                && !(ZERO_REG != 0 && i == 0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_en && clr_idx == IDX_W'(i)) regs[i] <= '0;
        else if (wsel[i])                    regs[i] <= write_data;
      end
    end
  end

  // Full power-of-two view so any index value decodes; unpopulated slots read zero.
  always_comb begin
    for (int j = 0; j < NSLOT; j++) view[j] = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (!(ZERO_REG != 0 && j == 0)) view[j] = regs[j];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wvalid;
  assign wvalid = |wsel;
`endif

  always_comb begin
    read_data_a = view[read_index_a];
    read_data_b = view[read_index_b];
`ifdef REGFILE_BYPASS_EN
    if (wvalid && write_index == read_index_a) read_data_a = write_data;
    if (wvalid && write_index == read_index_b) read_data_b = write_data;
`endif
    if (!reset) begin
      read_data_a = '0;
      read_data_b = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_param.sv
`default_nettype none
// tb_register_file_param: randomized and directed checks of two regfile configurations. Rev 1.0
module tb_register_file_param;

  localparam int W = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  // instance 0: DEPTH=4, ZERO_REG=0
  logic [1:0]   ra0, rb0, wi0;
  logic         we0, cr0, wr0, cb0, cd0;
  logic [W-1:0] wd0, da0, db0;
  // instance 1: DEPTH=5, ZERO_REG=1
  logic [2:0]   ra1, rb1, wi1;
  logic         we1, cr1, wr1, cb1, cd1;
  logic [W-1:0] wd1, da1, db1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] m0 [4];
  logic [W-1:0] m1 [5];
  bit idle0 = 1'b1;

  always #5 clk = ~clk;

  register_file_param #(.WIDTH(W), .DEPTH(4), .ZERO_REG(0)) u0 (
    .clk(clk), .reset(reset),
    .read_index_a(ra0), .read_data_a(da0), .read_index_b(rb0), .read_data_b(db0),
    .write_index(wi0), .write_enable(we0), .write_data(wd0), .write_ready(wr0),
    .clear_req(cr0), .clear_busy(cb0), .clear_done(cd0)
  );

  register_file_param #(.WIDTH(W), .DEPTH(5), .ZERO_REG(1)) u1 (
    .clk(clk), .reset(reset),
    .read_index_a(ra1), .read_data_a(da1), .read_index_b(rb1), .read_data_b(db1),
    .write_index(wi1), .write_enable(we1), .write_data(wd1), .write_ready(wr1),
    .clear_req(cr1), .clear_busy(cb1), .clear_done(cd1)
  );

  function automatic logic [W-1:0] exp0(input logic [1:0] idx);
    if (!reset) return '0;
    if (BYP && we0 && idle0 && wi0 == idx) return wd0;
    return m0[idx];
  endfunction

  function automatic logic [W-1:0] exp1(input logic [2:0] idx);
    if (!reset) return '0;
    if (idx >= 3'd5 || idx == 3'd0) return '0;
    if (BYP && we1 && wi1 == idx) return wd1;
    return m1[idx];
  endfunction

  task automatic zero_models();
    for (int i = 0; i < 4; i++) m0[i] = '0;
    for (int i = 0; i < 5; i++) m1[i] = '0;
  endtask

  // One clock edge; the models absorb whatever writes the rules say commit.
  task automatic commit();
    @(posedge clk);
    if (reset && idle0 && we0) m0[wi0] = wd0;
    if (reset && we1 && wi1 < 3'd5 && wi1 != 3'd0) m1[wi1] = wd1;
    #1;
  endtask

  task automatic test_reset();
    ra0 = 0; rb0 = 0; wi0 = 0; we0 = 0; wd0 = 0; cr0 = 0;
    ra1 = 0; rb1 = 0; wi1 = 0; we1 = 0; wd1 = 0; cr1 = 0;
    zero_models();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ra0 = 2'($urandom); rb0 = 2'($urandom); ra1 = 3'd4;
    #1;
    n_checks++;
    if (da0 !== '0 || db0 !== '0 || da1 !== '0) $display("FAIL reset_reads a0=%h b0=%h a1=%h want 0", da0, db0, da1);
    else n_pass++;
    n_checks++;
    if (wr0 !== 1'b0 || cb0 !== 1'b0 || cd0 !== 1'b0) $display("FAIL reset_flags ready=%b busy=%b done=%b want 000", wr0, cb0, cd0);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (wr0 !== 1'b1 || cb0 !== 1'b0 || cd0 !== 1'b0 || wr1 !== 1'b1) $display("FAIL release_flags ready=%b busy=%b done=%b want 100", wr0, cb0, cd0);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      ra0 = 2'(i); rb0 = 2'(3 - i);
      #1;
      n_checks++;
      if (da0 !== '0 || db0 !== '0) $display("FAIL release_reads idx=%0d a=%h b=%h want 0", i, da0, db0);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_rw(input int n);
    for (int c = 0; c < n; c++) begin
      we0 = 1'($urandom); wi0 = 2'($urandom); wd0 = 16'($urandom);
      ra0 = 2'($urandom); rb0 = 2'($urandom);
      we1 = 1'($urandom); wi1 = 3'($urandom); wd1 = 16'($urandom);
      ra1 = 3'($urandom); rb1 = 3'($urandom);
      if (c % 4 == 0) rb0 = wi0;
      if (c % 4 == 1) ra1 = wi1;
      #1;
      n_checks++;
      if (da0 !== exp0(ra0) || db0 !== exp0(rb0) || wr0 !== 1'b1)
        $display("FAIL rand_u0 c=%0d a[%0d]=%h/%h b[%0d]=%h/%h ready=%b", c, ra0, da0, exp0(ra0), rb0, db0, exp0(rb0), wr0);
      else n_pass++;
      n_checks++;
      if (da1 !== exp1(ra1) || db1 !== exp1(rb1) || wr1 !== 1'b1)
        $display("FAIL rand_u1 c=%0d a[%0d]=%h/%h b[%0d]=%h/%h ready=%b", c, ra1, da1, exp1(ra1), rb1, db1, exp1(rb1), wr1);
      else n_pass++;
      commit();
    end
    we0 = 0; we1 = 0;
  endtask

  task automatic test_latency();
    logic [W-1:0] old2, want;
    old2 = m0[2];
    we0 = 1; wi0 = 2; wd0 = 16'h1234; ra0 = 2; rb0 = 2;
    #1;
    want = BYP ? 16'h1234 : old2;
    n_checks++;
    if (da0 !== want || db0 !== want) $display("FAIL write_cycle a=%h b=%h want %h", da0, db0, want);
    else n_pass++;
    commit();
    we0 = 0;
    #1;
    n_checks++;
    if (da0 !== 16'h1234 || db0 !== 16'h1234) $display("FAIL after_write a=%h b=%h want 1234", da0, db0);
    else n_pass++;
    we1 = 1; wd1 = 16'hFFFF;
    wi1 = 0; commit();
    wi1 = 7; commit();
    wi1 = 4; commit();
    we1 = 0; ra1 = 0; rb1 = 7;
    #1;
    n_checks++;
    if (da1 !== '0 || db1 !== '0) $display("FAIL zero_reg_drop r0=%h r7=%h want 0", da1, db1);
    else n_pass++;
    ra1 = 4;
    #1;
    n_checks++;
    if (da1 !== 16'hFFFF) $display("FAIL zero_reg_idx4 got=%h want ffff", da1);
    else n_pass++;
  endtask

  task automatic test_bulk_clear(input bit chain);
    int nb;
    for (int i = 0; i < 4; i++) begin
      we0 = 1; wi0 = 2'(i); wd0 = 16'(i + 1);
      commit();
    end
    // request cycle also carries a write that must still land
    cr0 = 1; we0 = 1; wi0 = 3; wd0 = 16'($urandom);
    commit();
    idle0 = 0;
    for (int k = 0; k < 4; k++) begin
      cr0 = (k == 1);
      we0 = 1; wi0 = 2'($urandom); wd0 = 16'($urandom);
      ra0 = 2'($urandom); rb0 = 2'(k);
      #1;
      n_checks++;
      if (cb0 !== 1'b1 || wr0 !== 1'b0 || cd0 !== 1'b0) $display("FAIL clear_flags k=%0d busy=%b ready=%b done=%b want 100", k, cb0, wr0, cd0);
      else n_pass++;
      n_checks++;
      if (da0 !== exp0(ra0) || db0 !== exp0(rb0)) $display("FAIL clear_reads k=%0d a[%0d]=%h/%h b[%0d]=%h/%h", k, ra0, da0, exp0(ra0), rb0, db0, exp0(rb0));
      else n_pass++;
      commit();
      m0[k] = '0;
    end
    idle0 = 1; we0 = 0; cr0 = chain;
    #1;
    n_checks++;
    if (cb0 !== 1'b0 || cd0 !== 1'b1 || wr0 !== 1'b1) $display("FAIL clear_end busy=%b done=%b ready=%b want 011", cb0, cd0, wr0);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      ra0 = 2'(i);
      #1;
      n_checks++;
      if (da0 !== '0) $display("FAIL cleared_reg idx=%0d got=%h want 0", i, da0);
      else n_pass++;
    end
    commit();
    cr0 = 0;
    if (chain) begin
      idle0 = 0;
      nb = 0;
      while (cb0 === 1'b1 && nb < 10) begin
        nb++;
        commit();
      end
      idle0 = 1;
      n_checks++;
      if (nb != 4 || cd0 !== 1'b1) $display("FAIL chained_clear busy_cycles=%0d done=%b want 4 and 1", nb, cd0);
      else n_pass++;
      commit();
    end
    n_checks++;
    if (cd0 !== 1'b0 || cb0 !== 1'b0) $display("FAIL done_pulse done=%b busy=%b want 00", cd0, cb0);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    we0 = 1; wi0 = 1; wd0 = 16'hBEEF; ra0 = 1;
    commit();
    we0 = 0;
    #1;
    n_checks++;
    if (da0 !== 16'hBEEF) $display("FAIL beef_write got=%h want beef", da0);
    else n_pass++;
    @(negedge clk); #2;
    reset = 1'b0;
    zero_models();
    #1;
    n_checks++;
    if (da0 !== '0) $display("FAIL async_force got=%h want 0", da0);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (da0 !== '0) $display("FAIL reg1_after_reset got=%h want 0", da0);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      we0 = 1; wi0 = 2'(i); wd0 = 16'($urandom | 1);
      commit();
    end
    we0 = 0; cr0 = 1;
    commit();
    cr0 = 0; idle0 = 0;
    commit(); m0[0] = '0;
    commit(); m0[1] = '0;
    #2;
    reset = 1'b0;
    zero_models();
    idle0 = 1;
    #1;
    n_checks++;
    if (cb0 !== 1'b0 || cd0 !== 1'b0 || wr0 !== 1'b0) $display("FAIL abort_flags busy=%b done=%b ready=%b want 000", cb0, cd0, wr0);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      commit();
      n_checks++;
      if (cd0 !== 1'b0 || cb0 !== 1'b0) $display("FAIL abort_no_done c=%0d done=%b busy=%b want 00", c, cd0, cb0);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      ra0 = 2'(i);
      #1;
      n_checks++;
      if (da0 !== '0) $display("FAIL abort_regs idx=%0d got=%h want 0", i, da0);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_random_rw(80);
    test_latency();
    test_bulk_clear(1'b0);
    test_bulk_clear(1'b1);
    test_random_rw(30);
    test_reset_abort();
    test_random_rw(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
